// File: rtl/gcd_sequencer.sv
// Subtract-and-replace GCD control/register stage around an external magnitude comparator.
// Latency: N+1 cycles go-to-done (0 when an operand is zero); go is only accepted in IDLE, with no backpressure beyond that.
module gcd_sequencer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         lt,
  input  logic         neq,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out,
  output logic [W-1:0] gcd_out,
  output logic [W-1:0] iter_out,
  output logic         busy,
  output logic         done,
  output logic         zero_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       state_q, state_nxt;
  logic [W-1:0] x_q, x_nxt;
  logic [W-1:0] y_q, y_nxt;
  logic [W-1:0] gcd_q, gcd_nxt;
  logic [W-1:0] iter_q, iter_nxt;
  logic         zerr_q, zerr_nxt;
  logic [W-1:0] iter_inc;
  logic         a_zero, b_zero;

  assign a_zero = (a_in == '0);
  assign b_zero = (b_in == '0);

  // Counter sticks at all-ones instead of wrapping.
  assign iter_inc = (iter_q == '1) ? iter_q : iter_q + W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      gcd_q   <= '0;
      iter_q  <= '0;
      zerr_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      x_q     <= x_nxt;
      y_q     <= y_nxt;
      gcd_q   <= gcd_nxt;
      iter_q  <= iter_nxt;
      zerr_q  <= zerr_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    x_nxt     = x_q;
    y_nxt     = y_q;
    gcd_nxt   = gcd_q;
    iter_nxt  = iter_q;
    zerr_nxt  = zerr_q;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          x_nxt    = a_in;
          y_nxt    = b_in;
          iter_nxt = '0;
          zerr_nxt = 1'b0;
          if (a_zero && b_zero) begin
            gcd_nxt   = '0;
            zerr_nxt  = 1'b1;
            state_nxt = S_DONE;
          end else if (a_zero || b_zero) begin
            // A zero operand would never converge by subtraction.
            gcd_nxt   = a_zero ? b_in : a_in;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!neq) begin
          gcd_nxt   = x_q;
          state_nxt = S_DONE;
        end else if (lt) begin
          y_nxt    = y_q - x_q;
          iter_nxt = iter_inc;
        end else begin
          x_nxt    = x_q - y_q;
          iter_nxt = iter_inc;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign x_out    = x_q;
  assign y_out    = y_q;
  assign gcd_out  = gcd_q;
  assign iter_out = iter_q;
  assign zero_err = zerr_q;
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_gcd_sequencer.sv
// Scoreboarded bench for gcd_sequencer with a behavioural comparator on x_out/y_out.
module tb_gcd_sequencer;

  logic       clk;
  logic       rst;
  logic       go;
  logic [3:0] a_in, b_in;
  logic       lt, neq;
  logic [3:0] x_out, y_out, gcd_out, iter_out;
  logic       busy, done, zero_err;

  gcd_sequencer #(.W(4)) dut (
    .clk(clk), .rst(rst), .go(go), .a_in(a_in), .b_in(b_in),
    .lt(lt), .neq(neq), .x_out(x_out), .y_out(y_out),
    .gcd_out(gcd_out), .iter_out(iter_out), .busy(busy),
    .done(done), .zero_err(zero_err)
  );

  assign lt  = (x_out < y_out);
  assign neq = (x_out != y_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int gcd;
    int iter;
    int zerr;
    int done_cyc;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending result", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("gcd_out", int'(gcd_out), e.gcd);
        chk("iter_out", int'(iter_out), e.iter);
        chk("zero_err", int'(zero_err), e.zerr);
        chk("done_cycle", cyc, e.done_cyc);
      end
    end
  end

  task automatic drain(input string name);
    int waited;
    waited = 0;
    while (q.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk({name, "_drained"}, q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // delta = cycles from the accepting edge to the edge that enters DONE
  task automatic run(input int a, input int b, input int g, input int it,
                     input int ze, input int delta, input string name);
    int k;
    @(negedge clk);
    go = 1'b1; a_in = 4'(a); b_in = 4'(b);
    @(posedge clk);
    #1 k = cyc;
    q.push_back('{gcd: g, iter: it, zerr: ze, done_cyc: k + delta});
    @(negedge clk);
    go = 1'b0;
    chk({name, "_busy"}, int'(busy), (delta != 0) ? 1 : 0);
    drain(name);
  endtask

  initial begin
    int k;
    rst = 1'b1; go = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_x", int'(x_out), 0);
    chk("rst_gcd", int'(gcd_out), 0);
    chk("rst_flags", int'({busy, done, zero_err}), 0);
    rst = 1'b0;
    @(negedge clk);

    run(12, 8, 4, 2, 0, 3, "v12_8");
    run(15, 1, 1, 14, 0, 15, "v15_1");
    run(7, 7, 7, 0, 0, 1, "v7_7");
    run(0, 9, 9, 0, 0, 0, "v0_9");
    run(9, 0, 9, 0, 0, 0, "v9_0");
    run(0, 0, 0, 0, 1, 0, "v0_0");
    chk("zero_err_held", int'(zero_err), 1);
    chk("gcd_held", int'(gcd_out), 0);

    // go during RUN must be ignored
    @(negedge clk);
    go = 1'b1; a_in = 4'd9; b_in = 4'd6;
    @(posedge clk);
    #1 k = cyc;
    q.push_back('{gcd: 3, iter: 2, zerr: 0, done_cyc: k + 3});
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    go = 1'b1; a_in = 4'd5; b_in = 4'd5;
    @(negedge clk);
    go = 1'b0;
    drain("ignore_go");
    chk("no_restart_busy", int'(busy), 0);

    // go held high: second accept two edges after DONE
    @(negedge clk);
    go = 1'b1; a_in = 4'd4; b_in = 4'd6;
    @(posedge clk);
    #1 k = cyc;
    q.push_back('{gcd: 2, iter: 2, zerr: 0, done_cyc: k + 3});
    q.push_back('{gcd: 2, iter: 2, zerr: 0, done_cyc: k + 8});
    repeat (5) @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    drain("b2b");

    // asynchronous reset mid-RUN
    @(negedge clk);
    go = 1'b1; a_in = 4'd13; b_in = 4'd2;
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_x", int'(x_out), 0);
    chk("arst_y", int'(y_out), 0);
    chk("arst_gcd", int'(gcd_out), 0);
    chk("arst_iter", int'(iter_out), 0);
    chk("arst_flags", int'({busy, done, zero_err}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(6, 4, 2, 2, 0, 3, "v6_4");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
